// File: rtl/dual_lane_collector.sv
// Two-lane result collector: per-lane show-ahead FIFOs with advisory stall,
// sticky overflow and word counters, drained through a round-robin output port.

module dlc_lane #(
    parameter int DEPTH        = 4,
    parameter int STALL_THRESH = DEPTH - 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    input  logic        pop,
    output logic [31:0] head,
    output logic        empty,
    output logic        stall,
    output logic [15:0] rx_count,
    output logic        overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_OCC  = (AW+1)'(DEPTH);
    localparam logic [AW:0] STALL_OCC = (AW+1)'(STALL_THRESH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   occ, occ_nxt;
    logic          full, accept;

    assign full   = (occ == FULL_OCC);
    assign empty  = (occ == '0);
    assign head   = mem[rd_ptr];
    // A same-cycle pop frees the slot, so a full FIFO can still take a word.
    assign accept = in_valid && (!full || pop);

    always_comb begin
        occ_nxt = occ;
        if (accept && !pop)
            occ_nxt = occ + 1'b1;
        else if (!accept && pop)
            occ_nxt = occ - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (accept)
            mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            stall    <= 1'b0;
            rx_count <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr   <= wr_ptr + 1'b1;
                rx_count <= rx_count + 16'd1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            occ      <= occ_nxt;
            stall    <= (occ_nxt >= STALL_OCC);
            overflow <= overflow | (in_valid && full && !pop);
        end
    end
endmodule

module dual_lane_collector #(
    parameter int DEPTH        = 4,
    parameter int STALL_THRESH = DEPTH - 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pipeline1_outputs,
    input  logic [31:0] pipeline2_outputs,
    input  logic [1:0]  valid,
    output logic        stall_1,
    output logic        stall_2,
    output logic [31:0] out_data,
    output logic        out_lane,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] rx_count_1,
    output logic [15:0] rx_count_2,
    output logic [1:0]  overflow
);
    localparam int NUM_LANES = 2;

    logic [NUM_LANES-1:0][31:0] in_data, heads;
    logic [NUM_LANES-1:0][15:0] rx_count;
    logic [NUM_LANES-1:0]       empty, stall, pop;
    logic last_grant, rr_grant, grant, fire;
    logic hold_vld, hold_lane;

    assign in_data = {pipeline2_outputs, pipeline1_outputs};

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        dlc_lane #(.DEPTH(DEPTH), .STALL_THRESH(STALL_THRESH)) u_lane (
            .clk      (clk),
            .reset    (reset),
            .in_valid (valid[i]),
            .in_data  (in_data[i]),
            .pop      (pop[i]),
            .head     (heads[i]),
            .empty    (empty[i]),
            .stall    (stall[i]),
            .rx_count (rx_count[i]),
            .overflow (overflow[i])
        );
        assign pop[i] = fire && (grant == 1'(i));
    end

    // Both busy: alternate away from the last popped lane; else take the busy one.
    assign rr_grant  = (!empty[0] && !empty[1]) ? ~last_grant : empty[0];
    // A word offered but not taken stays on the port until it is popped.
    assign grant     = hold_vld ? hold_lane : rr_grant;
    assign out_valid = ~&empty;
    assign out_lane  = grant;
    assign out_data  = heads[grant];
    assign fire      = out_valid && out_ready;

    assign stall_1    = stall[0];
    assign stall_2    = stall[1];
    assign rx_count_1 = rx_count[0];
    assign rx_count_2 = rx_count[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b1;
            hold_vld   <= 1'b0;
            hold_lane  <= 1'b0;
        end else begin
            if (fire)
                last_grant <= grant;
            hold_vld  <= out_valid && !out_ready;
            hold_lane <= grant;
        end
    end
endmodule

// File: tb/tb_dual_lane_collector.sv
// Directed bench for dual_lane_collector: reset, single word, contention,
// backpressure/overflow, full-with-pop, output hold, mid-flight reset, counter wrap.

module tb_dual_lane_collector;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pipeline1_outputs, pipeline2_outputs;
    logic [1:0]  valid;
    logic        stall_1, stall_2;
    logic [31:0] out_data;
    logic        out_lane, out_valid, out_ready;
    logic [15:0] rx_count_1, rx_count_2;
    logic [1:0]  overflow;

    int checks = 0;
    int errors = 0;

    dual_lane_collector dut (
        .clk               (clk),
        .reset             (reset),
        .pipeline1_outputs (pipeline1_outputs),
        .pipeline2_outputs (pipeline2_outputs),
        .valid             (valid),
        .stall_1           (stall_1),
        .stall_2           (stall_2),
        .out_data          (out_data),
        .out_lane          (out_lane),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .rx_count_1        (rx_count_1),
        .rx_count_2        (rx_count_2),
        .overflow          (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; valid = 2'b00; out_ready = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; valid = 2'b00; out_ready = 1'b0;
        pipeline1_outputs = '0; pipeline2_outputs = '0;
        tick(); tick();
        reset = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if ({stall_2, stall_1} !== 2'b00) begin errors++; $display("FAIL reset_stall got %b exp 00", {stall_2, stall_1}); end
        checks++; if (rx_count_1 !== 16'd0 || rx_count_2 !== 16'd0) begin errors++; $display("FAIL reset_counts got %0d/%0d exp 0/0", rx_count_1, rx_count_2); end
        checks++; if (overflow !== 2'b00) begin errors++; $display("FAIL reset_overflow got %b exp 00", overflow); end
    endtask

    task automatic test_single();
        do_reset();
        valid = 2'b01; pipeline1_outputs = 32'hA5A5_0001; out_ready = 1'b1;
        tick();
        valid = 2'b00;
        checks++; if (out_valid !== 1'b1 || out_lane !== 1'b0 || out_data !== 32'hA5A5_0001) begin
            errors++; $display("FAIL single_word got v%b l%b %h exp v1 l0 a5a50001", out_valid, out_lane, out_data); end
        checks++; if (rx_count_1 !== 16'd1) begin errors++; $display("FAIL single_rx_count got %0d exp 1", rx_count_1); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_popped got %b exp 0", out_valid); end
    endtask

    task automatic test_contention();
        logic [31:0] exp_data [6] = '{32'h11, 32'h21, 32'h12, 32'h22, 32'h13, 32'h23};
        logic        exp_lane [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] got_data [$];
        logic        got_lane [$];
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            valid = (i < 3) ? 2'b11 : 2'b00;
            pipeline1_outputs = 32'h11 + 32'(i);
            pipeline2_outputs = 32'h21 + 32'(i);
            @(negedge clk);
            if (out_valid) begin got_data.push_back(out_data); got_lane.push_back(out_lane); end
            tick();
        end
        valid = 2'b00;
        checks++; if (got_data.size() != 6) begin errors++; $display("FAIL contention_count got %0d exp 6", got_data.size()); end
        for (int k = 0; k < 6 && k < got_data.size(); k++) begin
            checks++; if (got_lane[k] !== exp_lane[k] || got_data[k] !== exp_data[k]) begin
                errors++; $display("FAIL contention_word%0d got l%b %h exp l%b %h", k, got_lane[k], got_data[k], exp_lane[k], exp_data[k]); end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0; valid = 2'b01;
        for (int i = 0; i < 5; i++) begin
            pipeline1_outputs = 32'hB000_0000 + 32'(i);
            tick();
            if (i == 1) begin
                checks++; if (stall_1 !== 1'b0) begin errors++; $display("FAIL bp_stall_after2 got %b exp 0", stall_1); end
            end
            if (i == 2) begin
                checks++; if (stall_1 !== 1'b1) begin errors++; $display("FAIL bp_stall_after3 got %b exp 1", stall_1); end
            end
            if (i == 3) begin
                checks++; if (overflow !== 2'b00 || rx_count_1 !== 16'd4) begin
                    errors++; $display("FAIL bp_fill got ovf %b cnt %0d exp 00 4", overflow, rx_count_1); end
            end
        end
        valid = 2'b00;
        checks++; if (overflow !== 2'b01) begin errors++; $display("FAIL bp_overflow got %b exp 01", overflow); end
        checks++; if (rx_count_1 !== 16'd4) begin errors++; $display("FAIL bp_rx_count got %0d exp 4", rx_count_1); end
        checks++; if (out_data !== 32'hB000_0000 || stall_2 !== 1'b0) begin
            errors++; $display("FAIL bp_head got %h st2 %b exp b0000000 0", out_data, stall_2); end
    endtask

    task automatic test_full_pop();
        do_reset();
        out_ready = 1'b0; valid = 2'b01;
        for (int i = 0; i < 4; i++) begin
            pipeline1_outputs = 32'hC000_0000 + 32'(i);
            tick();
        end
        out_ready = 1'b1; pipeline1_outputs = 32'hC000_0004;
        tick();
        valid = 2'b00; out_ready = 1'b0;
        checks++; if (overflow !== 2'b00 || rx_count_1 !== 16'd5) begin
            errors++; $display("FAIL fullpop_accept got ovf %b cnt %0d exp 00 5", overflow, rx_count_1); end
        checks++; if (stall_1 !== 1'b1) begin errors++; $display("FAIL fullpop_stall got %b exp 1", stall_1); end
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b1 || out_data !== 32'hC000_0000 + 32'(k)) begin
                errors++; $display("FAIL fullpop_drain%0d got v%b %h exp v1 %h", k, out_valid, out_data, 32'hC000_0000 + 32'(k)); end
            tick();
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fullpop_empty got %b exp 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_hold();
        do_reset();
        out_ready = 1'b1; valid = 2'b01; pipeline1_outputs = 32'hD000_0000;
        tick();
        pipeline1_outputs = 32'hD000_0001;
        tick();
        out_ready = 1'b0; valid = 2'b00;
        tick();
        checks++; if (out_lane !== 1'b0 || out_data !== 32'hD000_0001) begin
            errors++; $display("FAIL hold_initial got l%b %h exp l0 d0000001", out_lane, out_data); end
        valid = 2'b10; pipeline2_outputs = 32'hE000_0001;
        tick();
        valid = 2'b00;
        for (int i = 0; i < 2; i++) begin
            checks++; if (out_lane !== 1'b0 || out_data !== 32'hD000_0001) begin
                errors++; $display("FAIL hold_stable%0d got l%b %h exp l0 d0000001", i, out_lane, out_data); end
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_lane !== 1'b0 || out_data !== 32'hD000_0001) begin
            errors++; $display("FAIL hold_release got l%b %h exp l0 d0000001", out_lane, out_data); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_lane !== 1'b1 || out_data !== 32'hE000_0001) begin
            errors++; $display("FAIL hold_next got v%b l%b %h exp v1 l1 e0000001", out_valid, out_lane, out_data); end
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b0; valid = 2'b01;
        for (int i = 0; i < 3; i++) begin
            pipeline1_outputs = 32'hF000_0000 + 32'(i);
            tick();
        end
        reset = 1'b1; valid = 2'b11; out_ready = 1'b1;
        tick();
        reset = 1'b0; valid = 2'b00; out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_out_valid got %b exp 0", out_valid); end
        checks++; if ({stall_2, stall_1} !== 2'b00) begin errors++; $display("FAIL midreset_stall got %b exp 00", {stall_2, stall_1}); end
        checks++; if (rx_count_1 !== 16'd0 || rx_count_2 !== 16'd0) begin
            errors++; $display("FAIL midreset_counts got %0d/%0d exp 0/0", rx_count_1, rx_count_2); end
    endtask

    task automatic test_wrap();
        do_reset();
        out_ready = 1'b1; valid = 2'b10;
        for (int i = 0; i < 65535; i++) begin
            pipeline2_outputs = 32'(i);
            tick();
        end
        checks++; if (rx_count_2 !== 16'hFFFF) begin errors++; $display("FAIL wrap_max got %h exp ffff", rx_count_2); end
        tick(); tick();
        valid = 2'b00;
        checks++; if (rx_count_2 !== 16'd1) begin errors++; $display("FAIL wrap_count got %0d exp 1", rx_count_2); end
        checks++; if (overflow !== 2'b00 || rx_count_1 !== 16'd0) begin
            errors++; $display("FAIL wrap_side got ovf %b cnt1 %0d exp 00 0", overflow, rx_count_1); end
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_full_pop();
        test_hold();
        test_reset_mid();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dual_lane_collector.md
DUAL_LANE_COLLECTOR -- requirements
Module: dual_lane_collector

Interface
REQ-001 SHALL have parameter DEPTH, default 4, entries per lane FIFO (power of two, >=2).
REQ-002 SHALL have parameter STALL_THRESH, default DEPTH-1, occupancy at or above which lane stall asserts.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port pipeline1_outputs  input  32  lane-1 result word.
REQ-006 SHALL have port pipeline2_outputs  input  32  lane-2 result word.
REQ-007 SHALL have port valid  input  2  bit0 qualifies lane 1, bit1 qualifies lane 2.
REQ-008 SHALL have port stall_1  output  1  backpressure to lane 1, registered.
REQ-009 SHALL have port stall_2  output  1  backpressure to lane 2, registered.
REQ-010 SHALL have port out_data  output  32  head word of the granted lane.
REQ-011 SHALL have port out_lane  output  1  0 = lane 1, 1 = lane 2; qualifies out_data.
REQ-012 SHALL have port out_valid  output  1  out_data/out_lane hold a word.
REQ-013 SHALL have port out_ready  input  1  downstream accepts the word this cycle.
REQ-014 SHALL have port rx_count_1 / rx_count_2  output  16 each  words accepted per lane.
REQ-015 SHALL have port overflow  output  2  sticky per-lane drop flag.

Function
REQ-016 SHALL push lane n word into FIFO n on any cycle with valid[n] high and (FIFO n not full, or a pop of lane n in the same cycle).
REQ-017 SHALL drop a lane n word arriving with FIFO n full and no same-cycle lane n pop: no FIFO change, rx_count unchanged, overflow[n] set until reset.
REQ-018 SHALL ignore stall_n when accepting; stall is advisory, and REQ-016/017 govern.
REQ-019 SHALL drive stall_n on the next cycle to 1 iff post-update occupancy of FIFO n >= STALL_THRESH (one-cycle latency, one free slot with defaults).
REQ-020 SHALL present FIFO heads show-ahead: out_valid = any FIFO non-empty, combinationally from state.
REQ-021 SHALL arbitrate round-robin: if both non-empty, grant the lane not granted at the last pop; if one non-empty, grant it.
REQ-022 SHALL hold out_data/out_lane stable while out_valid=1 and out_ready=0, regardless of new pushes into the other lane.
REQ-023 SHALL pop the granted head on out_valid & out_ready and update last-grant to that lane; out_ready with out_valid=0 has no effect.
REQ-024 SHALL preserve per-lane order: words exit a lane in arrival order.
REQ-025 SHALL accept simultaneous pushes on both lanes plus one pop in one cycle.
REQ-026 SHALL increment rx_count_n by 1 per accepted word, wrapping 0xFFFF -> 0x0000 with no flag.
REQ-027 SHALL wrap FIFO read/write pointers modulo DEPTH, with full/empty distinguished by an occupancy counter of width log2(DEPTH)+1.

Reset
REQ-028 SHALL, on reset high at a clock edge, empty both FIFOs, zero pointers, occupancies, rx_count_1/2 and overflow, and clear stall_1/stall_2.
REQ-029 SHALL set last-grant to lane 2 on reset so lane 1 wins the first contended grant.
REQ-030 SHALL, when reset is asserted mid-operation, discard all buffered words, ignore valid/out_ready that cycle, and give out_valid=0 the next cycle.

Verification
REQ-031 SHALL cover single word: valid=01, data 0xA5A5_0001, out_ready=1 -> out_valid=1, out_lane=0, out_data=0xA5A5_0001 the next cycle, popped, rx_count_1=1.
REQ-032 SHALL cover contention: both lanes push 0x11/0x22 each cycle for 3 cycles, out_ready=1 -> output sequence lane0,lane1,lane0,lane1,... with per-lane order 0x11s then 0x22s intact.
REQ-033 SHALL cover backpressure: out_ready=0, lane 1 pushes 3 words -> stall_1=1 the cycle after the 3rd push; a 4th push fills; a 5th push sets overflow[0]=1 and rx_count_1 stays 4.
REQ-034 SHALL cover full plus pop: FIFO 1 full, out_ready=1 and a lane 1 push in the same cycle -> word accepted, occupancy stays 4, overflow[0]=0.
REQ-035 SHALL cover hold: out_ready=0 with a lane 1 head showing, then lane 2 pushes -> out_lane/out_data unchanged until out_ready=1.
REQ-036 SHALL cover reset mid-flight and counter wrap: reset with 3 words buffered -> out_valid=0, stall=00, counts 0 the next cycle; 65537 accepted lane 2 words -> rx_count_2=1.
